// File: rtl/mem_access_unit.sv
// mem_access_unit: single-issue load/store execute stage.
//
// Accepts one memory uop from the memory issue queue, forms the effective
// address (rs1 + imm), issues a valid/ready request to data memory, waits for
// load data, aligns/extends it and writes it back to the PRF. ex_busy holds
// off further issue while an access is in flight.
//
// Optional feature macro: MEM_MISALIGN_CHECK_EN
//   defined   : misaligned H/W accesses are rejected (no request) and flagged
//               on misalign for one cycle.
//   undefined : misalign tied 0; low address bits are a lane offset and
//               strobes/data past the word are dropped.
//
// Ports:
//   clock, reset                  clock, synchronous active-high reset
//   clear_en                      pipeline flush
//   uop_in, rs1_data, rs2_data    issued uop and its operands
//   ex_busy                       back-pressure to the issue queue
//   mem_req_*                     data memory request (valid/ready)
//   mem_resp_valid/data           load response (aligned word)
//   wb_valid/prf_index/data       one-cycle PRF writeback
//   misalign                      one-cycle misalignment flag

package mem_access_pkg;
    localparam int PRF_INDEX_SIZE = 6;

    typedef enum logic [1:0] {
        MEM_NONE = 2'd0,
        MEM_LD   = 2'd1,
        MEM_ST   = 2'd2
    } mem_type_e;

    typedef struct packed {
        logic                      valid;
        mem_type_e                 mem_type;
        logic [1:0]                mem_size;      // 0=B, 1=H, 2=W
        logic                      mem_unsigned;
        logic [31:0]               imm;
        logic [PRF_INDEX_SIZE-1:0] rd_prf_index;
        logic                      rd_valid;
    } micro_op_t;
endpackage

module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int XLEN       = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear_en,
    input  micro_op_t                 uop_in,
    input  logic [XLEN-1:0]           rs1_data,
    input  logic [XLEN-1:0]           rs2_data,
    output logic                      ex_busy,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_WIDTH-1:0]     mem_req_addr,
    output logic                      mem_req_we,
    output logic [XLEN-1:0]           mem_req_wdata,
    output logic [3:0]                mem_req_wstrb,
    input  logic                      mem_resp_valid,
    input  logic [XLEN-1:0]           mem_resp_data,
    output logic                      wb_valid,
    output logic [PRF_INDEX_SIZE-1:0] wb_prf_index,
    output logic [XLEN-1:0]           wb_data,
    output logic                      misalign
);

    // MISAL is only reachable with the misalignment check enabled.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_WB    = 3'd3,
        S_DRAIN = 3'd4,
        S_MISAL = 3'd5
    } state_e;

    state_e state, state_n;

    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [1:0]                off_q;
    logic                      we_q;
    logic [XLEN-1:0]           wdata_q;
    logic [3:0]                wstrb_q;
    logic [1:0]                size_q;
    logic                      uns_q;
    logic [PRF_INDEX_SIZE-1:0] rd_q;
    logic                      rd_valid_q;
    logic [XLEN-1:0]           wb_data_q;

    // ---------------- issue-side address / lane computation ----------------
    logic [XLEN-1:0]       ea;
    logic [ADDR_WIDTH-1:0] ea_a;
    logic [1:0]            off;
    logic [3:0]            strb_n;
    logic [XLEN-1:0]       wdata_n;
    logic                  take;

    always_comb begin
        ea      = rs1_data + XLEN'(uop_in.imm);
        ea_a    = ADDR_WIDTH'(ea);
        off     = ea[1:0];
        case (uop_in.mem_size)
            2'd0:    strb_n = 4'b0001 << off;
            2'd1:    strb_n = 4'b0011 << off;   // off=3 drops the upper byte
            default: strb_n = 4'b1111;
        endcase
        wdata_n = rs2_data << {off, 3'b000};
    end

    // A flush in the same cycle blocks acceptance.
    assign take = (state == S_IDLE) && uop_in.valid && !clear_en &&
                  ((uop_in.mem_type == MEM_LD) || (uop_in.mem_type == MEM_ST));

`ifdef MEM_MISALIGN_CHECK_EN
    logic misal_n;
    assign misal_n = ((uop_in.mem_size == 2'd1) && off[0]) ||
                     ((uop_in.mem_size == 2'd2) && (off != 2'd0));
`endif

    // ---------------- load alignment / extension ----------------
    logic [XLEN-1:0] resp_sh;
    logic [XLEN-1:0] load_ext;

    always_comb begin
        resp_sh = mem_resp_data >> {off_q, 3'b000};
        case (size_q)
            2'd0:    load_ext = uns_q ? {{(XLEN-8){1'b0}}, resp_sh[7:0]}
                                      : {{(XLEN-8){resp_sh[7]}}, resp_sh[7:0]};
            2'd1:    load_ext = uns_q ? {{(XLEN-16){1'b0}}, resp_sh[15:0]}
                                      : {{(XLEN-16){resp_sh[15]}}, resp_sh[15:0]};
            default: load_ext = resp_sh;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (take) begin
`ifdef MEM_MISALIGN_CHECK_EN
                    state_n = misal_n ? S_MISAL : S_REQ;
`else
                    state_n = S_REQ;
`endif
                end
            end
            S_REQ: begin
                // An accepted request is committed even under flush; a load
                // then still owes a response and must be drained.
                if (mem_req_ready)  state_n = we_q ? S_IDLE : (clear_en ? S_DRAIN : S_WAIT);
                else if (clear_en)  state_n = S_IDLE;
            end
            S_WAIT: begin
                if (mem_resp_valid) state_n = clear_en ? S_IDLE : S_WB;
                else if (clear_en)  state_n = S_DRAIN;
            end
            S_WB:    state_n = S_IDLE;
            S_DRAIN: if (mem_resp_valid) state_n = S_IDLE;
            S_MISAL: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q     <= '0;
            off_q      <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
            wb_data_q  <= '0;
        end else begin
            if (take) begin
                addr_q     <= {ea_a[ADDR_WIDTH-1:2], 2'b00};
                off_q      <= off;
                we_q       <= (uop_in.mem_type == MEM_ST);
                wdata_q    <= wdata_n;
                wstrb_q    <= strb_n;
                size_q     <= uop_in.mem_size;
                uns_q      <= uop_in.mem_unsigned;
                rd_q       <= uop_in.rd_prf_index;
                rd_valid_q <= uop_in.rd_valid;
            end
            if ((state == S_WAIT) && mem_resp_valid) wb_data_q <= load_ext;
        end
    end

    // ---------------- outputs ----------------
    assign ex_busy       = (state != S_IDLE);
    assign mem_req_valid = (state == S_REQ);
    assign mem_req_addr  = addr_q;
    assign mem_req_we    = we_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wstrb = wstrb_q;
    // A flush during WB suppresses the write.
    assign wb_valid      = (state == S_WB) && rd_valid_q && !clear_en;
    assign wb_prf_index  = rd_q;
    assign wb_data       = wb_data_q;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign = (state == S_MISAL);
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Single-issue load/store execute stage directly downstream of the memory issue queue. Accepts one memory micro-op per issue (after PRF operand read), computes the effective address, drives a valid/ready request to the data memory, waits for load data, then aligns and extends it and writes it back to the PRF. It drives `ex_busy` back to the memory issue queue so that no uop is issued while an access is in flight.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte address width
- `XLEN`, 32, data width

Ports:
- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `clear_en`  in  1  pipeline flush (mispredict/exception)
- `uop_in`  in  micro_op_t  issued uop; uses `valid`, `mem_type` (MEM_LD/MEM_ST), `mem_size` (0=B,1=H,2=W), `mem_unsigned`, `imm`, `rd_prf_index`, `rd_valid`
- `rs1_data`  in  XLEN  base-address operand
- `rs2_data`  in  XLEN  store data operand
- `ex_busy`  out  1  to issue queue; 1 = do not issue
- `mem_req_valid`  out  1  request valid
- `mem_req_ready`  in  1  memory accepts request
- `mem_req_addr`  out  ADDR_WIDTH  word-aligned address (`[1:0]`=0)
- `mem_req_we`  out  1  1=store
- `mem_req_wdata`  out  XLEN  lane-shifted store data
- `mem_req_wstrb`  out  4  byte enables
- `mem_resp_valid`  in  1  load data valid (loads only)
- `mem_resp_data`  in  XLEN  aligned word read
- `wb_valid`  out  1  one-cycle PRF write
- `wb_prf_index`  out  `PRF_INDEX_SIZE`  destination
- `wb_data`  out  XLEN  extended load result
- `misalign`  out  1  one-cycle misalignment flag (see Configuration)

## Operation
- States: IDLE, REQ, WAIT, WB, DRAIN.
- IDLE: if `uop_in.valid` and `mem_type` is LD/ST, latch uop, `ea = rs1_data + imm` (mod 2^32), data/strobes; -> REQ. Other uops ignored.
- Strobes: B `4'b0001<<ea[1:0]`; H `4'b0011<<ea[1:0]`; W `4'b1111`. `wdata = rs2_data << (8*ea[1:0])`.
- REQ: `mem_req_valid`=1, all request outputs stable until `mem_req_ready`. On accept: store -> IDLE (posted, no writeback); load -> WAIT.
- WAIT: on `mem_resp_valid`, select byte/half at `ea[1:0]`, sign-extend unless `mem_unsigned`; register result -> WB.
- WB: `wb_valid = rd_valid` for one cycle; `rd_valid`=0 loads (rd=x0) complete silently; -> IDLE.
- `ex_busy` = (state != IDLE); combinational from state only.
- `clear_en`: IDLE/REQ/WB -> IDLE, latched uop dropped, no writeback; a REQ not yet accepted is withdrawn. WAIT -> DRAIN (response still owed). DRAIN: ignore `uop_in`, discard next `mem_resp_valid`, -> IDLE. `clear_en` in DRAIN stays DRAIN. `clear_en` in same cycle as a valid `uop_in` in IDLE: uop not accepted.
- `mem_req_ready` and `clear_en` same cycle in REQ: clear wins for loads only if request not accepted — rule: if ready=1 the request is accepted; load -> DRAIN, store -> IDLE (store committed).
- `mem_resp_valid` outside WAIT/DRAIN ignored.

## Timing
- Reset: state IDLE; `ex_busy`, `mem_req_valid`, `mem_req_we`, `wb_valid`, `misalign` = 0; `mem_req_addr`, `wdata`, `wstrb`, `wb_data`, `wb_prf_index` = 0.
- Accept cycle T; `mem_req_valid` high from T+1.
- Load, ready at T+1, resp at T+2: `wb_valid` at T+3 (min load latency 3 cycles after accept).
- Store, ready at T+1: `ex_busy` low at T+2; next uop acceptable at T+2.
- Backpressure: each cycle of `mem_req_ready`=0 or missing response adds one cycle.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined: in IDLE, H with `ea[0]`=1 or W with `ea[1:0]`!=0 -> no request, `misalign`=1 for one cycle at T+1, state returns to IDLE (`ex_busy` high only in T+1).
- Undefined: `misalign` tied 0; address low bits are used as lane offset, strobes truncated to 4 bits (bytes past the word dropped).

## Test plan
- Load word: rs1=0x1000, imm=4, resp=0xDEADBEEF, ready immediate -> addr 0x1004, `wb_data`=0xDEADBEEF at T+3, `ex_busy` high T+1..T+3.
- Load byte signed at ea=0x1003, resp=0x80FFFFFF -> `wb_data`=0xFFFFFF80; same unsigned -> 0x00000080.
- Store half ea=0x2002, rs2=0x1234ABCD, ready held 0 for 3 cycles -> wdata=0xABCD0000, wstrb=0b1100 stable throughout, no `wb_valid`.
- `clear_en` in WAIT, resp 2 cycles later -> DRAIN, no `wb_valid`, `ex_busy` low the cycle after resp; then new load completes normally.
- Reset asserted in REQ -> next cycle all outputs at reset values, pending request dropped.
- With `MEM_MISALIGN_CHECK_EN`: load word ea=0x1002 -> `misalign`=1 at T+1, `mem_req_valid` never asserted.
